// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - architectural register file with RAW/WAW scoreboard
// Optional writeback-to-decode forwarding: define REGFILE_BYPASS_EN.
module regfile_scoreboard #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] wb_reg,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              flush,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] rs1_addr,
   input  logic [ADDR_W-1:0] rs2_addr,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rs1_data,
   output logic [DATA_W-1:0] rs2_data
);

   localparam int NREG = 1 << ADDR_W;

   logic [DATA_W-1:0] r_regs [NREG];
   logic [NREG-1:0]   r_pending;
   logic              r_rsp_valid;
   logic [DATA_W-1:0] r_rs1_data;
   logic [DATA_W-1:0] r_rs2_data;

   logic              w_wb_en;
   logic              w_byp_rs1;
   logic              w_byp_rs2;
   logic              w_byp_rd;
   logic              w_accept;
   logic [NREG-1:0]   w_pending_next;
   logic [DATA_W-1:0] w_rs1_val;
   logic [DATA_W-1:0] w_rs2_val;

   assign w_wb_en = (wb_reg != '0);

`ifdef REGFILE_BYPASS_EN
   assign w_byp_rs1 = w_wb_en && (wb_reg == rs1_addr);
   assign w_byp_rs2 = w_wb_en && (wb_reg == rs2_addr);
   assign w_byp_rd  = w_wb_en && (wb_reg == rd_addr);
`else
   assign w_byp_rs1 = 1'b0;
   assign w_byp_rs2 = 1'b0;
   assign w_byp_rd  = 1'b0;
`endif

   assign req_ready = !flush
                   && !(r_pending[rs1_addr] && !w_byp_rs1)
                   && !(r_pending[rs2_addr] && !w_byp_rs2)
                   && !(r_pending[rd_addr]  && !w_byp_rd);

   assign w_accept = req_valid && req_ready;

   assign w_rs1_val = (rs1_addr == '0) ? '0 : (w_byp_rs1 ? wb_data : r_regs[rs1_addr]);
   assign w_rs2_val = (rs2_addr == '0) ? '0 : (w_byp_rs2 ? wb_data : r_regs[rs2_addr]);

   // Order matters: a reservation in the same cycle overrides the writeback clear.
   always_comb begin
      w_pending_next = r_pending;
      if (w_wb_en)
         w_pending_next[wb_reg] = 1'b0;
      if (flush)
         w_pending_next = '0;
      if (w_accept && (rd_addr != '0))
         w_pending_next[rd_addr] = 1'b1;
      w_pending_next[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++)
            r_regs[i] <= '0;
         r_pending   <= '0;
         r_rsp_valid <= 1'b0;
         r_rs1_data  <= '0;
         r_rs2_data  <= '0;
      end else begin
         if (w_wb_en)
            r_regs[wb_reg] <= wb_data;
         r_pending   <= w_pending_next;
         r_rsp_valid <= w_accept;
         if (w_accept) begin
            r_rs1_data <= w_rs1_val;
            r_rs2_data <= w_rs2_val;
         end
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rs1_data  = r_rs1_data;
   assign rs2_data  = r_rs2_data;

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Architectural register file with a scoreboard. It sits between the decode stage, which reads operands and reserves destinations, and the MEM/WB pipeline register, which delivers `reg_write` / `data_write` each cycle. The block:
- absorbs writebacks;
- tracks which registers have an in-flight producer;
- stalls decode on RAW and WAW hazards;
- returns both source operands one cycle after a request is accepted.

## Interface
Parameters:
- `DATA_W`, 32: register width; matches `COMMON_WIDTH`.
- `ADDR_W`, 5: register index width; matches `REG_NUM`; the file holds 2^ADDR_W entries.

Ports:
- `clk`  input  1  clock; all state updates on its rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `wb_reg`  input  ADDR_W  writeback destination from MEM/WB; 0 means no write this cycle.
- `wb_data`  input  DATA_W  writeback value.
- `flush`  input  1  pipeline flush; clears every pending bit.
- `req_valid`  input  1  decode presents an operand-read request.
- `req_ready`  output  1  request can be accepted this cycle (combinational).
- `rs1_addr`  input  ADDR_W  source 1 index.
- `rs2_addr`  input  ADDR_W  source 2 index.
- `rd_addr`  input  ADDR_W  destination to reserve; 0 means none.
- `rsp_valid`  output  1  operands valid; a one-cycle pulse.
- `rs1_data`  output  DATA_W  registered source 1 value.
- `rs2_data`  output  DATA_W  registered source 2 value.

## Operation
- **Storage.** `regs[0..2^ADDR_W-1]` holds the register values and `pending[]` holds one bit per register. Entry 0 always reads 0 and is never pending; writes to it are ignored.
- **Writeback.** If `wb_reg != 0`, then at the clock edge `regs[wb_reg] <= wb_data` and `pending[wb_reg] <= 0`. Writeback is unconditional: it is never stalled and never blocked by `flush`.
- **Effective pending.** `eff_pend[r] = pending[r] && !(bypass_hit on r)`, where `bypass_hit` means `wb_reg == r != 0` and the bypass is compiled in (see Configuration).
- **Ready.** `req_ready = !flush && !eff_pend[rs1_addr] && !eff_pend[rs2_addr] && !eff_pend[rd_addr]`.
  - The `rd_addr` term provides the WAW stall.
  - `req_ready` does not depend on `req_valid`.
- **Accept.** Acceptance is `req_valid && req_ready`. At the next edge:
  - `rsp_valid <= 1`;
  - `rsX_data <= (bypass_hit on rsX) ? wb_data : regs[rsX_addr]`, with index 0 giving 0;
  - if `rd_addr != 0`, then `pending[rd_addr] <= 1`.
- **No accept.** `rsp_valid <= 0`; `rs1_data` and `rs2_data` hold their previous values.
- **Same register written back and reserved in one cycle.** The set from the accepted request wins, so the bit ends up 1.
- **Flush.** At the edge, `pending` becomes all zeros. `req_ready` is 0 during a flush cycle, so no reservation is made in that cycle. A writeback in the same cycle still updates `regs`.
- **No internal state machine.** Block state is the `regs` array, the `pending` vector and the output registers.

## Timing
- **Reset values.**
  - Asserting `rst` immediately forces all `regs` to 0, `pending` to 0, `rsp_valid` to 0, and `rs1_data` / `rs2_data` to 0.
  - `req_ready` evaluates to 1 while `rst` is held, but requests are ignored until the first edge after deassertion.
- **Read latency.** One cycle from acceptance to `rsp_valid`; back-to-back accepts give `rsp_valid` on consecutive cycles.
- **Write-to-read.**
  - With bypass, data written back in cycle N is visible to a request accepted in cycle N.
  - Without bypass, it is visible to a request accepted in cycle N+1.
- **Reset mid-operation.** Reservations are discarded. Any `rsp_valid` that was due is suppressed.

## Configuration
- **`REGFILE_BYPASS_EN` defined.**
  - `bypass_hit` is active.
  - A writeback clears its register's hazard in the same cycle and its data is forwarded into `rsX_data`.
- **`REGFILE_BYPASS_EN` undefined.**
  - `bypass_hit` is constantly 0.
  - A pending register stalls decode through its writeback cycle; operands come from `regs` only.
  - Minimum RAW turnaround is one cycle longer.

## Test plan
- **Reset.** Assert `rst` mid-cycle, then release and request `rs1=3`, `rs2=0` -> outputs go 0 immediately; the response next cycle is `rs1_data=0`, `rs2_data=0`, `rsp_valid=1`.
- **Basic write/read.** `wb_reg=5`, `wb_data=0xDEADBEEF`; next cycle request `rs1=5`, `rs2=5` -> both outputs `0xDEADBEEF` one cycle later.
- **RAW stall.**
  - Setup: accept `rd=7`, then request `rs1=7`.
  - Expected: `req_ready=0` until writeback `wb_reg=7`, `wb_data=0x12`.
  - With bypass: ready in the writeback cycle and `rs1_data=0x12`.
  - Without bypass: ready one cycle later.
- **WAW plus simultaneous set/clear.**
  - Setup: reserve `rd=9`; in the cycle `wb_reg=9` arrives (bypass on), present a new request with `rd=9`.
  - Expected: accepted, and `pending[9]` remains 1 (verified by a stall on a following `rs1=9` request).
- **Flush.** Reserve `rd=4` and `rd=6`, then assert `flush` together with `req_valid` (`rd=8`) -> `req_ready=0`; afterwards requests on `4`, `6`, `8` are accepted immediately.
- **x0.**
  - Stimulus: `wb_reg=0`, `wb_data=0xFFFF`; then request `rs1=0` with `rd=0`.
  - Expected: `rs1_data=0`, nothing is reserved, and `req_ready` stays 1.
